icache_ifill_unit: RTL

Refill engine between the instruction cache and the upper memory level. It accepts a single line-miss request from the icache fill port and issues one burst read to memory. Narrow memory beats are packed into icache-width fill beats and returned with a beat index. The final beat carries the completion ack that the icache uses to clear its in-flight flag. A flush during a refill lets the memory burst finish, discards its data, and holds any new miss until the old burst has drained.

---
 rtl/drac_icache_pkg.sv | 15 +
 rtl/ifill_beat_packer.sv | 47 ++++
 rtl/icache_ifill_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/drac_icache_pkg.sv
// rtl/drac_icache_pkg.sv - shared icache refill types and constants
package drac_icache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    DRAIN   = 2'd3
  } ifill_state_t;

  localparam int ICACHE_FILL_BEATS  = 4;
  localparam int ICACHE_MEM_DATA_W  = 64;
  localparam int ICACHE_FILL_DATA_W = 128;

endpackage

// File: rtl/ifill_beat_packer.sv
// rtl/ifill_beat_packer.sv - packs narrow memory beats into one fill-width word
module ifill_beat_packer
  import drac_icache_pkg::*;
#(
  parameter int MEM_DATA_W  = ICACHE_MEM_DATA_W,
  parameter int FILL_DATA_W = ICACHE_FILL_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   clr_i,
  input  logic                   beat_valid_i,
  input  logic [MEM_DATA_W-1:0]  beat_data_i,
  output logic                   full_o,
  output logic [FILL_DATA_W-1:0] word_o
);

  localparam int R     = FILL_DATA_W / MEM_DATA_W;
  localparam int SUB_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(R - 1);

  logic [SUB_W-1:0]       sub_cnt_q;
  logic [FILL_DATA_W-1:0] pack_q;

  // The word seen this cycle already includes the incoming beat, so the
  // completing beat can be registered straight into the fill output.
  always_comb begin
    word_o = pack_q;
    word_o[int'(sub_cnt_q) * MEM_DATA_W +: MEM_DATA_W] = beat_data_i;
  end

  assign full_o = beat_valid_i && (sub_cnt_q == SUB_LAST);

  // Slot counter and pack register, least-significant slot filled first
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sub_cnt_q <= '0;
      pack_q    <= '0;
    end else if (clr_i) begin
      sub_cnt_q <= '0;
      pack_q    <= '0;
    end else if (beat_valid_i) begin
      pack_q    <= word_o;
      sub_cnt_q <= full_o ? '0 : sub_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/icache_ifill_unit.sv
// rtl/icache_ifill_unit.sv - icache line refill engine with flush drain and pending miss slot
module icache_ifill_unit
  import drac_icache_pkg::*;
#(
  parameter int PADDR_W     = 34,
  parameter int WAY_W       = 2,
  parameter int MEM_DATA_W  = ICACHE_MEM_DATA_W,
  parameter int FILL_DATA_W = ICACHE_FILL_DATA_W,
  parameter int FILL_BEATS  = ICACHE_FILL_BEATS
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic                          ifill_req_valid_i,
  input  logic [PADDR_W-1:0]            ifill_req_paddr_i,
  input  logic [WAY_W-1:0]              ifill_req_way_i,
  output logic                          ifill_resp_valid_o,
  output logic                          ifill_resp_ack_o,
  output logic [$clog2(FILL_BEATS)-1:0] ifill_resp_beat_o,
  output logic [FILL_DATA_W-1:0]        ifill_resp_data_o,
  output logic [WAY_W-1:0]              ifill_resp_way_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [PADDR_W-1:0]            mem_req_paddr_o,
  input  logic                          mem_resp_valid_i,
  input  logic [MEM_DATA_W-1:0]         mem_resp_data_i
);

  localparam int BEAT_W = $clog2(FILL_BEATS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FILL_BEATS - 1);

  ifill_state_t state_q, state_d;

  logic [PADDR_W-1:0]     paddr_q;
  logic [WAY_W-1:0]       way_q;
  logic [BEAT_W-1:0]      beat_cnt_q;
  logic                   pend_valid_q;
  logic [PADDR_W-1:0]     pend_paddr_q;
  logic [WAY_W-1:0]       pend_way_q;

  logic                   launch;
  logic                   launch_pend;
  logic                   emit;
  logic                   pack_beat;
  logic                   pack_full;
  logic                   line_done;
  logic                   pend_set;
  logic                   pend_clr;
  logic [FILL_DATA_W-1:0] pack_word;

  // Memory beats only count while a burst is outstanding
  assign pack_beat = mem_resp_valid_i && (state_q == COLLECT || state_q == DRAIN);
  assign line_done = pack_full && (beat_cnt_q == BEAT_LAST);

  ifill_beat_packer #(
    .MEM_DATA_W  (MEM_DATA_W),
    .FILL_DATA_W (FILL_DATA_W)
  ) u_packer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (launch),
    .beat_valid_i (pack_beat),
    .beat_data_i  (mem_resp_data_i),
    .full_o       (pack_full),
    .word_o       (pack_word)
  );

  // Next state, launch decode and fill-beat emission
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_pend = 1'b0;
    emit        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (pend_valid_q) begin
            launch      = 1'b1;
            launch_pend = 1'b1;
            state_d     = REQ;
          end else if (ifill_req_valid_i) begin
            launch  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A flush coinciding with the handshake still owes us a burst
        if (mem_req_ready_i) begin
          state_d = flush_i ? DRAIN : COLLECT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        emit = pack_full && !flush_i;
        if (line_done) begin
          state_d = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (line_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requests seen while draining, or alongside a flush of an active refill,
  // are parked; any flush otherwise empties the slot.
  assign pend_set = ifill_req_valid_i &&
                    (state_q == DRAIN ||
                     (flush_i && (state_q == REQ || state_q == COLLECT)));
  assign pend_clr = flush_i || launch_pend;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Line address, way and fill-beat counter for the active refill
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      paddr_q    <= '0;
      way_q      <= '0;
      beat_cnt_q <= '0;
    end else if (launch) begin
      paddr_q    <= launch_pend ? pend_paddr_q : ifill_req_paddr_i;
      way_q      <= launch_pend ? pend_way_q : ifill_req_way_i;
      beat_cnt_q <= '0;
    end else if (pack_full) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // Single-entry pending miss slot
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_valid_q <= 1'b0;
      pend_paddr_q <= '0;
      pend_way_q   <= '0;
    end else if (pend_set) begin
      pend_valid_q <= 1'b1;
      pend_paddr_q <= ifill_req_paddr_i;
      pend_way_q   <= ifill_req_way_i;
    end else if (pend_clr) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Registered fill response, all fields zero when not valid
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ifill_resp_valid_o <= 1'b0;
      ifill_resp_ack_o   <= 1'b0;
      ifill_resp_beat_o  <= '0;
      ifill_resp_data_o  <= '0;
      ifill_resp_way_o   <= '0;
    end else if (emit) begin
      ifill_resp_valid_o <= 1'b1;
      ifill_resp_ack_o   <= line_done;
      ifill_resp_beat_o  <= beat_cnt_q;
      ifill_resp_data_o  <= pack_word;
      ifill_resp_way_o   <= way_q;
    end else begin
      ifill_resp_valid_o <= 1'b0;
      ifill_resp_ack_o   <= 1'b0;
      ifill_resp_beat_o  <= '0;
      ifill_resp_data_o  <= '0;
      ifill_resp_way_o   <= '0;
    end
  end

  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_paddr_o = paddr_q;

  mem_resp_in_burst: assert property (@(posedge clk_i) disable iff (!rstn_i)
    mem_resp_valid_i |-> (state_q == COLLECT || state_q == DRAIN));

endmodule
